// File: rtl/midi_parameter_transmitter.sv
// Parameter-change detector feeding a MIDI Control Change transmitter.
// One CC message per changed field, 8N1 serial, lowest field index first.

package MIDI;
    localparam logic [7:0] CONTROL_CHANGE = 8'hB0;
    localparam logic [6:0] TEMPO          = 7'd20;
    localparam logic [6:0] UNISON         = 7'd21;
    localparam logic [6:0] ATTACK         = 7'd73;
    localparam logic [6:0] DECAY          = 7'd75;
    localparam logic [6:0] SUSTAIN        = 7'd79;
    localparam logic [6:0] RELEASE        = 7'd72;
    localparam logic [6:0] VOLUME         = 7'd7;
endpackage

package PARAMETER;
    localparam int FIELD_COUNT = 7;

    typedef struct packed {
        logic [6:0] tempo;
        logic [6:0] unison_detune;
        logic [6:0] attack_time;
        logic [6:0] decay_time;
        logic [6:0] sustain_level;
        logic [6:0] release_time;
        logic [6:0] volume;
    } parameter_t;
endpackage

module midi_parameter_transmitter #(
    parameter logic [3:0] CHANNEL      = 4'd0,
    parameter int         CLKS_PER_BIT = 1600
) (
    input  logic                  clock_50_000_000,
    input  logic                  reset,
    input  PARAMETER::parameter_t parameters,
    input  logic                  dump,
    output logic                  midi_tx,
    output logic                  busy
);

    localparam int NF = PARAMETER::FIELD_COUNT;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [6:0]    tx_value;
    logic [6:0]    tx_ctrl;

    logic [6:0]    field         [NF];
    logic [6:0]    snapshot      [NF];
    logic [6:0]    snapshot_next [NF];
    logic [NF-1:0] pending;
    logic [NF-1:0] pending_next;

    logic [2:0]    sel;
    logic          has_pending;
    logic          latch;
    logic          bit_end;
    logic [7:0]    tx_byte;

    // Flatten the bundle into an indexable list in priority order.
    always_comb begin
        field[0] = parameters.tempo;
        field[1] = parameters.unison_detune;
        field[2] = parameters.attack_time;
        field[3] = parameters.decay_time;
        field[4] = parameters.sustain_level;
        field[5] = parameters.release_time;
        field[6] = parameters.volume;
    end

    function automatic logic [6:0] ctrl_of(input logic [2:0] idx);
        logic [6:0] c;
        c = MIDI::VOLUME;
        unique case (idx)
            3'd0:    c = MIDI::TEMPO;
            3'd1:    c = MIDI::UNISON;
            3'd2:    c = MIDI::ATTACK;
            3'd3:    c = MIDI::DECAY;
            3'd4:    c = MIDI::SUSTAIN;
            3'd5:    c = MIDI::RELEASE;
            default: c = MIDI::VOLUME;
        endcase
        return c;
    endfunction

    // Pick the lowest-index pending field.
    always_comb begin
        sel = 3'd0;
        for (int i = NF - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = 3'(i);
            end
        end
        has_pending = |pending;
        latch       = (state == IDLE) && has_pending;
    end

    // Latched field's snapshot takes its current value, so its own
    // compare below sees no difference on the latch edge.
    always_comb begin
        for (int i = 0; i < NF; i++) begin
            if (latch && (sel == 3'(i))) begin
                snapshot_next[i] = field[i];
            end else begin
                snapshot_next[i] = snapshot[i];
            end
            pending_next[i] = (pending[i] & ~(latch && (sel == 3'(i))))
                            | dump
                            | (field[i] != snapshot_next[i]);
        end
    end

    // Byte currently being framed: status, controller, value.
    always_comb begin
        tx_byte = {1'b0, tx_value};
        unique case (byte_idx)
            2'd0:    tx_byte = MIDI::CONTROL_CHANGE | {4'h0, CHANNEL};
            2'd1:    tx_byte = {1'b0, tx_ctrl};
            default: tx_byte = {1'b0, tx_value};
        endcase
    end

    assign bit_end = (clk_cnt == LAST_CLK);

    // Track what was last sent and which fields still owe a message.
    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NF; i++) begin
                snapshot[i] <= '0;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < NF; i++) begin
                snapshot[i] <= snapshot_next[i];
            end
            pending <= pending_next;
        end
    end

    // Serial framer: start, 8 data bits LSB first, stop; three bytes.
    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_value <= '0;
            tx_ctrl  <= '0;
            midi_tx  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (has_pending) begin
                        tx_value <= field[sel];
                        tx_ctrl  <= ctrl_of(sel);
                        byte_idx <= 2'd0;
                        clk_cnt  <= '0;
                        midi_tx  <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        midi_tx <= tx_byte[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            midi_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            midi_tx <= tx_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (byte_idx != 2'd2) begin
                            byte_idx <= byte_idx + 2'd1;
                            midi_tx  <= 1'b0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Busy reflects the previous cycle's framer and queue state.
    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
        end else begin
            busy <= (state != IDLE) | (|pending);
        end
    end

endmodule

// File: tb/tb_midi_parameter_transmitter.sv
// Bench for midi_parameter_transmitter: message-level model, per-cycle
// line/busy compare, UART decode of both channel instances.
module tb_midi_parameter_transmitter;

    localparam int CPB  = 8;
    localparam int MSG  = 30 * CPB;
    localparam logic [6:0] CTRL [7] = '{7'd20, 7'd21, 7'd73, 7'd75,
                                        7'd79, 7'd72, 7'd7};

    logic clk = 1'b0;
    logic reset;
    logic dump;
    logic [6:0] pv [7];
    PARAMETER::parameter_t params;
    logic tx0, tx3, busy0, busy3;
    logic [1:0] txl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign params = {pv[0], pv[1], pv[2], pv[3], pv[4], pv[5], pv[6]};
    assign txl    = {tx3, tx0};

    midi_parameter_transmitter #(.CHANNEL(4'd0), .CLKS_PER_BIT(CPB)) u_ch0 (
        .clock_50_000_000(clk),
        .reset(reset),
        .parameters(params),
        .dump(dump),
        .midi_tx(tx0),
        .busy(busy0)
    );

    midi_parameter_transmitter #(.CHANNEL(4'd3), .CLKS_PER_BIT(CPB)) u_ch3 (
        .clock_50_000_000(clk),
        .reset(reset),
        .parameters(params),
        .dump(dump),
        .midi_tx(tx3),
        .busy(busy3)
    );

    // Model: a message is a 30-bit-time window started by the lowest
    // pending field whenever the line is free.
    logic [6:0] m_snap [7];
    bit         m_pend [7];
    bit         m_act;
    int         m_t;
    logic [6:0] m_ctrl, m_val;
    logic       m_busy;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act  = 0;
            m_t    = 0;
            m_busy = 0;
            m_ctrl = '0;
            m_val  = '0;
            for (int i = 0; i < 7; i++) begin
                m_snap[i] = '0;
                m_pend[i] = 0;
            end
        end else begin
            bit any;
            int s;
            any = 0;
            s   = 0;
            for (int i = 0; i < 7; i++) begin
                if (m_pend[i] && !any) begin
                    any = 1;
                    s   = i;
                end
            end
            m_busy = m_act || any;
            if (m_act) begin
                m_t++;
                if (m_t == MSG) m_act = 0;
            end else if (any) begin
                m_val     = pv[s];
                m_ctrl    = CTRL[s];
                m_snap[s] = pv[s];
                m_pend[s] = 0;
                m_act     = 1;
                m_t       = 0;
            end
            for (int i = 0; i < 7; i++) begin
                if (dump || pv[i] != m_snap[i]) m_pend[i] = 1;
            end
        end
    end

    function automatic logic exp_bit(int t, logic [7:0] st,
                                     logic [6:0] c, logic [6:0] v);
        int f, p;
        logic [7:0] b;
        f = t / (10 * CPB);
        p = (t % (10 * CPB)) / CPB;
        b = (f == 0) ? st : (f == 1) ? {1'b0, c} : {1'b0, v};
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p - 1];
    endfunction

    logic [7:0] rxq0 [$];
    logic [7:0] rxq3 [$];
    bit         rx_act  [2];
    int         rx_cnt  [2];
    logic [7:0] rx_byte [2];

    // Per-cycle compare against the model, plus serial decode.
    always @(negedge clk) begin
        logic e0, e3;
        e0 = m_act ? exp_bit(m_t, 8'hB0, m_ctrl, m_val) : 1'b1;
        e3 = m_act ? exp_bit(m_t, 8'hB3, m_ctrl, m_val) : 1'b1;
        total++;
        if (tx0 !== e0 || tx3 !== e3 || busy0 !== m_busy || busy3 !== m_busy) begin
            bad++;
            if (bad < 40)
                $display("FAIL cycle t=%0t tx0=%b want %b tx3=%b want %b busy=%b%b want %b",
                         $time, tx0, e0, tx3, e3, busy0, busy3, m_busy);
        end
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                rx_act[k] = 0;
            end else if (!rx_act[k]) begin
                if (!txl[k]) begin
                    rx_act[k] = 1;
                    rx_cnt[k] = 0;
                end
            end else begin
                rx_cnt[k]++;
                if (rx_cnt[k] == 9 * CPB + CPB / 2) begin
                    total++;
                    if (!txl[k]) begin
                        bad++;
                        $display("FAIL stop_bit line%0d got=0 want=1", k);
                    end
                    if (k == 0) rxq0.push_back(rx_byte[k]);
                    else        rxq3.push_back(rx_byte[k]);
                    rx_act[k] = 0;
                end else if (rx_cnt[k] >= CPB && rx_cnt[k] % CPB == CPB / 2) begin
                    rx_byte[k][rx_cnt[k] / CPB - 1] = txl[k];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic expect_msg(input string name, input bit ch3, input int idx,
                              input logic [7:0] s, input logic [7:0] c,
                              input logic [7:0] v);
        int sz;
        logic [23:0] g;
        sz = ch3 ? rxq3.size() : rxq0.size();
        total++;
        if (sz < idx + 3) begin
            bad++;
            $display("FAIL %s got bytes=%0d want>=%0d", name, sz, idx + 3);
        end else begin
            for (int j = 0; j < 3; j++)
                g[23 - 8*j -: 8] = ch3 ? rxq3[idx + j] : rxq0[idx + j];
            if (g !== {s, c, v}) begin
                bad++;
                $display("FAIL %s got=%06h want=%06h", name, g, {s, c, v});
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy0 || busy3) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy0 || busy3) begin
            bad++;
            $display("FAIL %s timeout busy=%b%b want=00", name, busy0, busy3);
        end
    endtask

    initial begin
        int b0, b3, falls, lowbusy, n;
        reset = 1'b1;
        dump  = 1'b0;
        for (int i = 0; i < 7; i++) pv[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_tx", {30'd0, tx3, tx0}, 32'h3);
        chk("reset_busy", {30'd0, busy3, busy0}, 32'h0);
        reset = 1'b0;

        falls = 0;
        repeat (2000) begin
            @(negedge clk);
            if (!tx0 || !tx3) falls++;
        end
        chk("idle_quiet", falls, 0);

        // Single change: attack 0 -> 64.
        b0 = rxq0.size();
        b3 = rxq3.size();
        pv[2] = 7'd64;
        @(negedge clk);
        chk("latency_edge1", {31'd0, tx0}, 1);
        @(negedge clk);
        chk("latency_edge2", {31'd0, tx0}, 0);
        wait_idle("attack_idle");
        expect_msg("attack_ch0", 0, b0, 8'hB0, 8'h49, 8'h40);
        expect_msg("attack_ch3", 1, b3, 8'hB3, 8'h49, 8'h40);

        // Two fields at once: tempo first, then volume.
        b0 = rxq0.size();
        pv[0] = 7'd10;
        pv[6] = 7'd100;
        repeat (3) @(negedge clk);
        lowbusy = 0;
        n = 0;
        while (rxq0.size() < b0 + 6 && n < 2000) begin
            if (!busy0) lowbusy++;
            @(negedge clk);
            n++;
        end
        chk("pair_busy_held", lowbusy, 0);
        wait_idle("pair_idle");
        expect_msg("pair_tempo", 0, b0, 8'hB0, 8'h14, 8'h0A);
        expect_msg("pair_volume", 0, b0 + 3, 8'hB0, 8'h07, 8'h64);
        chk("pair_count", rxq0.size(), b0 + 6);

        // Change during byte 2: old value goes out, new one follows.
        b0 = rxq0.size();
        pv[2] = 7'd5;
        repeat (2) @(negedge clk);
        repeat (23 * CPB) @(negedge clk);
        pv[2] = 7'd9;
        wait_idle("resend_idle");
        expect_msg("resend_first", 0, b0, 8'hB0, 8'h49, 8'h05);
        expect_msg("resend_second", 0, b0 + 3, 8'hB0, 8'h49, 8'h09);

        // Dump with every field nonzero.
        b3 = rxq3.size();
        for (int i = 0; i < 7; i++) pv[i] = 7'($urandom_range(1, 127));
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        repeat (2) @(negedge clk);
        wait_idle("dump_idle");
        for (int i = 0; i < 7; i++)
            expect_msg("dump_msg", 1, b3 + 3 * i, 8'hB3, {1'b0, CTRL[i]}, {1'b0, pv[i]});
        chk("dump_count", rxq3.size(), b3 + 21);

        // Random traffic.
        repeat (9000) begin
            @(negedge clk);
            dump = 1'b0;
            if ($urandom_range(0, 149) == 0)
                pv[$urandom_range(0, 6)] = 7'($urandom);
            if ($urandom_range(0, 1999) == 0)
                dump = 1'b1;
        end
        @(negedge clk);
        dump = 1'b0;
        wait_idle("random_idle");

        // Reset in the middle of a data bit.
        pv[3] = 7'($urandom_range(1, 127)) ^ pv[3];
        repeat (2) @(negedge clk);
        repeat (2 * CPB + 3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("reset_mid_tx", {30'd0, tx3, tx0}, 32'h3);
        chk("reset_mid_busy", {30'd0, busy3, busy0}, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 7; i++) pv[i] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        falls = 0;
        repeat (500) begin
            @(negedge clk);
            if (!tx0 || !tx3 || busy0 || busy3) falls++;
        end
        chk("post_reset_quiet", falls, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
